max_pool2: RTL and testbench

MAX_POOL2 -- requirements
Module: max_pool2

---
 rtl/max_pool2_pkg.sv | 22 ++
 rtl/pool_line_buf.sv | 30 +++
 rtl/max_pool2.sv | 100 ++++++++++
 tb/tb_max_pool2.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_pool2_pkg.sv
// ---------------------------------------------------------------------------
// max_pool2_pkg : shared CNN constants and 2x2 window position encoding | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package max_pool2_pkg;

  localparam int CNN_DATA_W  = 22;
  localparam int CONV1_OUT_W = 24;
  localparam int CONV1_OUT_H = 24;

  // Position of the current sample inside its 2x2 window: {row[0], col[0]}
  typedef enum logic [1:0] {
    WIN_TL = 2'b00,
    WIN_TR = 2'b01,
    WIN_BL = 2'b10,
    WIN_BR = 2'b11
  } win_pos_e;

endpackage

`default_nettype wire

// File: rtl/pool_line_buf.sv
// ---------------------------------------------------------------------------
// pool_line_buf : one-write/one-read line buffer of top-row pair maxima | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pool_line_buf #(
  parameter int DATA_W = 22,
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Contents are never reset: every entry is rewritten on an even row before use.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/max_pool2.sv
// ---------------------------------------------------------------------------
// max_pool2 : streaming 2x2 / stride-2 signed max pooling over a raster frame | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module max_pool2
  import max_pool2_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int IMG_W  = CONV1_OUT_W,
  parameter int IMG_H  = CONV1_OUT_H
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     pool_valid,
  output logic signed [DATA_W-1:0] pool_data,
  output logic                     frame_done
);

  localparam int COL_W     = $clog2(IMG_W);
  localparam int ROW_W     = $clog2(IMG_H);
  localparam int BUF_DEPTH = IMG_W / 2;
  localparam int ADDR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [COL_W-1:0]         r_col;
  logic [ROW_W-1:0]         r_row;
  logic signed [DATA_W-1:0] r_pair;
  logic signed [DATA_W-1:0] w_line_rd;
  logic signed [DATA_W-1:0] w_pair_max;
  logic signed [DATA_W-1:0] w_win_max;
  logic [ADDR_W-1:0]        w_addr;
  logic                     w_buf_we;
  logic                     w_last_col;
  logic                     w_last_row;
  win_pos_e                 w_pos;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign w_pos      = win_pos_e'({r_row[0], r_col[0]});
  assign w_addr     = ADDR_W'(r_col >> 1);
  assign w_last_col = (r_col == COL_W'(IMG_W - 1));
  assign w_last_row = (r_row == ROW_W'(IMG_H - 1));
  assign w_pair_max = smax(r_pair, in_data);
  assign w_win_max  = smax(w_pair_max, w_line_rd);
  assign w_buf_we   = in_valid && !rst && (w_pos == WIN_TR);

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (w_buf_we),
    .wr_addr (w_addr),
    .wr_data (w_pair_max),
    .rd_addr (w_addr),
    .rd_data (w_line_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_pair     <= '0;
      pool_data  <= '0;
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        case (w_pos)
          WIN_TL, WIN_BL: r_pair <= in_data;
          WIN_BR: begin
            pool_data  <= w_win_max;
            pool_valid <= 1'b1;
            frame_done <= w_last_col && w_last_row;
          end
          default: ;
        endcase
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_max_pool2.sv
// ---------------------------------------------------------------------------
// tb_max_pool2 : randomized self-checking bench with a frame-array max model | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_max_pool2;

  localparam int DW = 22;
  typedef logic signed [DW-1:0] s_t;
  typedef struct {
    int   cyc;
    s_t   d;
    logic fd;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vs = 1'b0, vb = 1'b0;
  s_t   ds = '0, db = '0;
  logic pvs, pvb, fds, fdb;
  s_t   pds, pdb;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  ev_t obs_s[$], obs_b[$], exp_s[$], exp_b[$];
  ev_t mon_s, mon_b;
  s_t  pix [24][24];

  max_pool2 #(.DATA_W(DW), .IMG_W(4), .IMG_H(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(vs), .in_data(ds),
    .pool_valid(pvs), .pool_data(pds), .frame_done(fds)
  );

  max_pool2 #(.DATA_W(DW), .IMG_W(24), .IMG_H(24)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_data(db),
    .pool_valid(pvb), .pool_data(pdb), .frame_done(fdb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (pvs || fds) begin
        mon_s.cyc = cyc; mon_s.d = pds; mon_s.fd = fds;
        obs_s.push_back(mon_s);
      end
      if (pvb || fdb) begin
        mon_b.cyc = cyc; mon_b.d = pdb; mon_b.fd = fdb;
        obs_b.push_back(mon_b);
      end
    end
  end

  function automatic s_t rnd();
    logic [31:0] t;
    t = $urandom;
    return s_t'(t[DW-1:0]);
  endfunction

  function automatic s_t max4(input s_t a, input s_t b, input s_t c, input s_t d);
    s_t v [4];
    s_t m;
    v = '{a, b, c, d};
    m = v[0];
    foreach (v[i]) if (v[i] > m) m = v[i];
    return m;
  endfunction

  task automatic drive(input bit big, input bit v, input s_t d);
    @(negedge clk);
    if (big) begin vb = v; db = d; end
    else begin vs = v; ds = d; end
  endtask

  // Streams pix in raster order; each bottom-right sample predicts its window output
  task automatic send_frame(input bit big, input int w, input int h, input int idle, input int nsamp);
    int  k;
    ev_t e;
    k = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (k < nsamp) begin
          drive(big, 1'b1, pix[r][c]);
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.cyc = cyc + 1;
            e.d   = max4(pix[r-1][c-1], pix[r-1][c], pix[r][c-1], pix[r][c]);
            e.fd  = (r == h - 1) && (c == w - 1);
            if (big) exp_b.push_back(e); else exp_s.push_back(e);
          end
          k++;
          for (int i = 0; i < idle; i++) drive(big, 1'b0, rnd());
        end
      end
    end
  endtask

  task automatic flush(input bit big);
    drive(big, 1'b0, '0);
    repeat (4) @(negedge clk);
  endtask

  task automatic load_small(input s_t a0, input s_t a1, input s_t a2, input s_t a3,
                            input s_t b0, input s_t b1, input s_t b2, input s_t b3);
    pix[0][0] = a0; pix[0][1] = a1; pix[0][2] = a2; pix[0][3] = a3;
    pix[1][0] = b0; pix[1][1] = b1; pix[1][2] = b2; pix[1][3] = b3;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({pvs, fds, pds} !== '0) begin
      n_err++; $display("FAIL reset_small: got pv=%0b fd=%0b data=%0d expected 0 0 0", pvs, fds, pds);
    end
    n_cmp++;
    if ({pvb, fdb, pdb} !== '0) begin
      n_err++; $display("FAIL reset_big: got pv=%0b fd=%0b data=%0d expected 0 0 0", pvb, fdb, pdb);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({pvs, pds, pvb, pdb} !== '0) begin
      n_err++; $display("FAIL reset_release: got pv_s=%0b d_s=%0d pv_b=%0b d_b=%0d expected zeros", pvs, pds, pvb, pdb);
    end
  endtask

  task automatic test_directed(input int idle, input string tag);
    load_small(1, 5, 2, 0, 3, 4, 9, -1);
    send_frame(1'b0, 4, 2, idle, 8);
    flush(1'b0);
    n_cmp++;
    if (obs_s.size() != exp_s.size()) begin
      n_err++; $display("FAIL %s_count: got %0d expected %0d", tag, obs_s.size(), exp_s.size());
    end
    for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
      n_cmp++;
      if (obs_s[i].cyc !== exp_s[i].cyc || obs_s[i].d !== exp_s[i].d || obs_s[i].fd !== exp_s[i].fd) begin
        n_err++; $display("FAIL %s_ev%0d: got cyc=%0d data=%0d fd=%0b expected cyc=%0d data=%0d fd=%0b",
                          tag, i, obs_s[i].cyc, obs_s[i].d, obs_s[i].fd, exp_s[i].cyc, exp_s[i].d, exp_s[i].fd);
      end
    end
    if (obs_s.size() == 2) begin
      n_cmp++;
      if (obs_s[0].d !== 22'sd5 || obs_s[1].d !== 22'sd9 || obs_s[0].fd !== 1'b0 || obs_s[1].fd !== 1'b1) begin
        n_err++; $display("FAIL %s_values: got %0d/%0b %0d/%0b expected 5/0 9/1",
                          tag, obs_s[0].d, obs_s[0].fd, obs_s[1].d, obs_s[1].fd);
      end
    end
    obs_s.delete(); exp_s.delete();
  endtask

  task automatic test_negative();
    load_small(-7, -3, rnd(), rnd(), -9, -4, rnd(), rnd());
    send_frame(1'b0, 4, 2, 1, 8);
    flush(1'b0);
    n_cmp++;
    if (obs_s.size() != 2) begin
      n_err++; $display("FAIL neg_count: got %0d expected 2", obs_s.size());
    end else begin
      n_cmp++;
      if (obs_s[0].d !== -22'sd3) begin
        n_err++; $display("FAIL neg_window: got %0d expected -3", obs_s[0].d);
      end
      n_cmp++;
      if (obs_s[1].d !== exp_s[1].d || obs_s[1].cyc !== exp_s[1].cyc) begin
        n_err++; $display("FAIL neg_second: got %0d@%0d expected %0d@%0d", obs_s[1].d, obs_s[1].cyc, exp_s[1].d, exp_s[1].cyc);
      end
    end
    obs_s.delete(); exp_s.delete();
  endtask

  task automatic test_extremes_reset();
    load_small(22'sd2097151, -22'sd2097152, 22'sd7, 22'sd3, -22'sd1, 22'sd0, 22'sd1, 22'sd2);
    send_frame(1'b0, 4, 2, 0, 8);
    flush(1'b0);
    n_cmp++;
    if (obs_s.size() != 2) begin
      n_err++; $display("FAIL ext_count: got %0d expected 2", obs_s.size());
    end else begin
      n_cmp++;
      if (obs_s[0].d !== 22'sd2097151) begin
        n_err++; $display("FAIL ext_window: got %0d expected 2097151", obs_s[0].d);
      end
    end
    obs_s.delete(); exp_s.delete();
    // Partial frame then reset: outputs must clear during and right after reset
    load_small(2, 8, 1, 1, 1, 1, 1, 1);
    send_frame(1'b0, 4, 2, 0, 6);
    drive(1'b0, 1'b0, '0);
    #2 rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pvs !== 1'b0 || pds !== '0) begin
      n_err++; $display("FAIL ext_in_reset: got pv=%0b data=%0d expected 0 0", pvs, pds);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pvs !== 1'b0 || pds !== '0) begin
      n_err++; $display("FAIL ext_after_reset: got pv=%0b data=%0d expected 0 0", pvs, pds);
    end
    obs_s.delete(); exp_s.delete();
  endtask

  task automatic test_back_to_back();
    int nfd;
    for (int f = 0; f < 2; f++) begin
      foreach (pix[r, c]) pix[r][c] = rnd();
      send_frame(1'b1, 24, 24, 0, 576);
    end
    flush(1'b1);
    n_cmp++;
    if (obs_b.size() != 288) begin
      n_err++; $display("FAIL b2b_count: got %0d expected 288", obs_b.size());
    end
    nfd = 0;
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      n_cmp++;
      if (obs_b[i].cyc !== exp_b[i].cyc || obs_b[i].d !== exp_b[i].d || obs_b[i].fd !== exp_b[i].fd) begin
        n_err++; $display("FAIL b2b_ev%0d: got cyc=%0d data=%0d fd=%0b expected cyc=%0d data=%0d fd=%0b",
                          i, obs_b[i].cyc, obs_b[i].d, obs_b[i].fd, exp_b[i].cyc, exp_b[i].d, exp_b[i].fd);
      end
    end
    foreach (obs_b[i]) if (obs_b[i].fd) nfd++;
    n_cmp++;
    if (nfd != 2) begin
      n_err++; $display("FAIL b2b_frame_done: got %0d expected 2", nfd);
    end
    obs_b.delete(); exp_b.delete();
  endtask

  task automatic test_mid_reset();
    foreach (pix[r, c]) pix[r][c] = rnd();
    send_frame(1'b1, 24, 24, 0, 30);
    drive(1'b1, 1'b0, '0);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (pix[r, c]) pix[r][c] = rnd();
    send_frame(1'b1, 24, 24, ($urandom_range(0, 3) == 0) ? 1 : 0, 576);
    flush(1'b1);
    n_cmp++;
    if (obs_b.size() != exp_b.size()) begin
      n_err++; $display("FAIL midrst_count: got %0d expected %0d", obs_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      n_cmp++;
      if (obs_b[i].cyc !== exp_b[i].cyc || obs_b[i].d !== exp_b[i].d || obs_b[i].fd !== exp_b[i].fd) begin
        n_err++; $display("FAIL midrst_ev%0d: got cyc=%0d data=%0d fd=%0b expected cyc=%0d data=%0d fd=%0b",
                          i, obs_b[i].cyc, obs_b[i].d, obs_b[i].fd, exp_b[i].cyc, exp_b[i].d, exp_b[i].fd);
      end
    end
    obs_b.delete(); exp_b.delete();
  endtask

  initial begin
    test_reset();
    test_directed(0, "dir");
    test_directed(3, "idle");
    test_negative();
    test_extremes_reset();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
